// File: rtl/input_debounce.sv
// Two-flop synchronizers and a tick-paced stability filter for the
// board buttons and switches, with a one-cycle press pulse per key.
module input_debounce #(
    parameter int N_KEY        = 4,
    parameter int N_SW         = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_KEY-1:0] key_pin,
    input  logic [N_SW-1:0]  sw_pin,
    output logic [N_KEY-1:0] key,
    output logic [N_SW-1:0]  sw,
    output logic [N_KEY-1:0] key_press,
    output logic             tick
);

    localparam int N  = N_KEY + N_SW;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_PRE   = PW'(TICK_DIV - 2);
    localparam logic [CW-1:0] C_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [N-1:0]  RST_VAL = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

    // Keys sit in the low bits, switches above them; every bit is
    // filtered by the same rule, only the idle level differs.
    logic [N-1:0]  pin_all;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  deb;
    logic [N-1:0]  mismatch;
    logic [N-1:0]  accept;
    logic [PW-1:0] pcnt;
    logic          tick_q;
    logic [CW-1:0] cnt [N];
    logic [N_KEY-1:0] press_q;

    assign pin_all = {sw_pin, key_pin};

    // Two-flop synchronizer bringing the raw pins into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= pin_all;
            sync2 <= sync1;
        end
    end

    // Prescaler; the strobe is registered so it lines up with count TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
        end else begin
            if (pcnt == P_LAST) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            tick_q <= (pcnt == P_PRE);
        end
    end

    // A bit is accepted on the tick that completes its stable run.
    always_comb begin
        mismatch = sync2 ^ deb;
        accept   = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = mismatch[i] & tick_q & (cnt[i] == C_LAST);
        end
    end

    // Per-bit stability counters; any return to the old level restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= RST_VAL;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!mismatch[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else if (tick_q) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press pulse coincides with the accepting update of a 1->0 key change.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q <= '0;
        end else begin
            press_q <= accept[N_KEY-1:0] & deb[N_KEY-1:0];
        end
    end

    assign key       = deb[N_KEY-1:0];
    assign sw        = deb[N-1:N_KEY];
    assign key_press = press_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: two instances (3 and 1 stable ticks) driven
// by one stimulus stream and compared against an arithmetic model.
module tb_input_debounce;

    localparam int TD = 4;
    localparam int NK = 4;
    localparam int NS = 10;
    localparam int N  = NK + NS;
    localparam logic [N-1:0] RSTV = 14'h000F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_pin = 4'hF;
    logic [9:0]  sw_pin = '0;

    logic [3:0]  key_a, kp_a, key_b, kp_b;
    logic [9:0]  sw_a, sw_b;
    logic        tick_a, tick_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_debounce #(
        .N_KEY(NK), .N_SW(NS), .TICK_DIV(TD), .STABLE_TICKS(3)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .key_pin(key_pin), .sw_pin(sw_pin),
        .key(key_a), .sw(sw_a),
        .key_press(kp_a), .tick(tick_a)
    );

    input_debounce #(
        .N_KEY(NK), .N_SW(NS), .TICK_DIV(TD), .STABLE_TICKS(1)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .key_pin(key_pin), .sw_pin(sw_pin),
        .key(key_b), .sw(sw_b),
        .key_press(kp_b), .tick(tick_b)
    );

    // Reference state: pin delay line, edge index since reset, and for each
    // instance the accepted levels plus the edge at which a differing run began.
    logic [N-1:0] ms1, ms2;
    int           mn;
    bit           mtick;
    logic [N-1:0] mdeb [2];
    logic [3:0]   mpress [2];
    int           mstart [2][N];
    bit           mrun [2][N];
    bit           armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int st_of(input int c);
        return (c == 0) ? 3 : 1;
    endfunction

    // Sample ticks fall on edges m with m a multiple of TD (m >= 1).
    function automatic int ticks_in(input int a, input int b);
        return (b / TD) - ((a - 1) / TD);
    endfunction

    task automatic model_edge();
        logic [N-1:0] raw, s2_old, d_old;
        raw = {sw_pin, key_pin};
        if (reset) begin
            mn    = 0;
            ms1   = RSTV;
            ms2   = RSTV;
            mtick = 1'b0;
            for (int c = 0; c < 2; c++) begin
                mdeb[c]   = RSTV;
                mpress[c] = '0;
                for (int i = 0; i < N; i++) mrun[c][i] = 1'b0;
            end
            armed = 1'b1;
        end else begin
            s2_old = ms2;
            mn++;
            mtick = ((mn % TD) == TD - 1);
            for (int c = 0; c < 2; c++) begin
                d_old     = mdeb[c];
                mpress[c] = '0;
                for (int i = 0; i < N; i++) begin
                    if (s2_old[i] == d_old[i]) begin
                        mrun[c][i] = 1'b0;
                    end else begin
                        if (!mrun[c][i]) begin
                            mrun[c][i]   = 1'b1;
                            mstart[c][i] = mn;
                        end
                        if ((mn % TD) == 0 &&
                            ticks_in(mstart[c][i], mn) == st_of(c)) begin
                            mdeb[c][i] = s2_old[i];
                            mrun[c][i] = 1'b0;
                            if (i < NK && d_old[i]) mpress[c][i] = 1'b1;
                        end
                    end
                end
            end
            ms2 = ms1;
            ms1 = raw;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (armed) begin
            check("a.key",   key_a,  mdeb[0][3:0]);
            check("a.sw",    sw_a,   mdeb[0][13:4]);
            check("a.press", kp_a,   mpress[0]);
            check("a.tick",  tick_a, mtick);
            check("b.key",   key_b,  mdeb[1][3:0]);
            check("b.sw",    sw_b,   mdeb[1][13:4]);
            check("b.press", kp_b,   mpress[1]);
            check("b.tick",  tick_b, mtick);
        end
    endtask

    initial begin
        int lat, lb, pulses, ticks;
        bit ok, any_p;
        logic [3:0] pva, pvb, ka, kb;

        // Reset held three cycles, then tick cadence.
        reset = 1'b1;
        repeat (3) step();
        check("rst.key", key_a, 4'hF);
        check("rst.sw", sw_a, 0);
        check("rst.tick", tick_a, 0);
        reset = 1'b0;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            ticks += int'(tick_a);
        end
        check("tick.count", ticks, 3);

        // Single press and its latency window.
        key_pin[0] = 1'b0;
        lat = 0;
        pva = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (lat == 0 && key_a[0] == 1'b0) begin
                lat = k;
                pva = kp_a;
            end
        end
        check($sformatf("press.lat=%0d", lat), (lat >= 11 && lat <= 14), 1);
        check("press.vec", pva, 4'b0001);
        key_pin[0] = 1'b1;
        repeat (20) step();

        // Bouncing key: no change during bounce, one pulse after settling.
        ok = 1'b1;
        pulses = 0;
        for (int s = 0; s < 8; s++) begin
            key_pin[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 5; k++) begin
                step();
                if (key_a[1] !== 1'b1) ok = 1'b0;
                pulses += int'(kp_a[1]);
            end
        end
        key_pin[1] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            pulses += int'(kp_a[1]);
        end
        check("bounce.hold", ok, 1);
        check("bounce.pulses", pulses, 1);
        key_pin[1] = 1'b1;
        repeat (20) step();

        // Switches follow with no press pulses.
        any_p = 1'b0;
        sw_pin = 10'h2A5;
        for (int k = 0; k < 20; k++) begin
            step();
            any_p |= (|kp_a) | (|kp_b);
        end
        check("sw.set", sw_a, 10'h2A5);
        sw_pin = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            any_p |= (|kp_a) | (|kp_b);
        end
        check("sw.clr", sw_a, 0);
        check("sw.nopress", any_p, 0);

        // Reset in the middle of a run restarts filtering.
        key_pin[2] = 1'b0;
        repeat (8) step();
        check("mid.before", key_a[2], 1);
        reset = 1'b1;
        step();
        check("mid.rst_key_b", key_b, 4'hF);
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat == 0 && key_a[2] == 1'b0) lat = k;
        end
        check("mid.relat", lat, 3 * TD);
        key_pin[2] = 1'b1;
        repeat (20) step();

        // All keys pressed together.
        key_pin = 4'h0;
        lat = 0; lb = 0;
        pva = '0; pvb = '0; ka = 4'hF; kb = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat == 0 && kp_a != 0) begin
                lat = k; pva = kp_a; ka = key_a;
            end
            if (lb == 0 && kp_b != 0) begin
                lb = k; pvb = kp_b; kb = key_b;
            end
        end
        check("simul.a_press", pva, 4'hF);
        check("simul.a_key", ka, 4'h0);
        check("simul.b_press", pvb, 4'hF);
        check("simul.b_key", kb, 4'h0);
        key_pin = 4'hF;
        repeat (20) step();

        // Random pin activity with occasional resets.
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                key_pin = 4'($urandom);
                sw_pin  = 10'($urandom);
            end else begin
                key_pin[$urandom_range(0, 3)] ^= 1'b1;
                sw_pin[$urandom_range(0, 9)]  ^= 1'b1;
            end
            reset = ($urandom_range(0, 39) == 0);
            step();
            reset = 1'b0;
            repeat ($urandom_range(1, 16)) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
